encoder_batch_dispatcher: RTL and testbench

Hardware replacement for the sequential per-file start/finish loop that drives a single encoder. It accepts one batch job (first file index, file count) and dispatches file indices round-robin-by-availability across N_ENG parallel encoder instances. It drives each engine's start/file_index and collects each engine's level finish. It reports batch completion with a one-cycle pulse. It sits between the top-level controller and an array of encoder instances.

---
 rtl/encoder_batch_pkg.sv | 32 +++
 rtl/encoder_batch_slot.sv | 94 +++++++++
 rtl/encoder_batch_dispatcher.sv | 147 ++++++++++++++
 tb/tb_encoder_batch_dispatcher.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_batch_pkg.sv
`default_nettype none
//==============================================================================
// Module   : encoder_batch_pkg
// Desc     : Shared state encodings and counter sizing for the batch dispatcher.
// Revision : 1.0 - initial release
//==============================================================================
package encoder_batch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } batch_state_t;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_START = 2'd1,
        SLOT_RUN   = 2'd2
    } slot_state_t;

    // One counter covers both the start-hold window and the watchdog window.
    function automatic int slot_cnt_w(input int start_cycles, input int timeout_cycles);
        int w_max;
        w_max = (start_cycles > timeout_cycles) ? start_cycles : timeout_cycles;
        return $clog2(w_max) + 1;
    endfunction

    localparam int C_SLOT_CNT_W = slot_cnt_w(3, 4096);

endpackage
`default_nettype wire

// File: rtl/encoder_batch_slot.sv
`default_nettype none
//==============================================================================
// Module   : encoder_batch_slot
// Desc     : Per-engine FREE/START/RUN tracker with start-hold counter.
//            Optional macro: WATCHDOG_EN (frees a hung engine after timeout).
// Revision : 1.0 - initial release
//==============================================================================
module encoder_batch_slot #(
    parameter int START_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dispatch,
    input  logic i_clear_timeout,
    input  logic i_finish,
    output logic o_start,
    output logic o_free,
    output logic o_finished,
    output logic o_timeout
);
    import encoder_batch_pkg::*;

    localparam int                 c_cnt_w      = slot_cnt_w(START_CYCLES, TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);

    slot_state_t        r_state;
    slot_state_t        w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_expired;
    logic               w_counting;

`ifdef WATCHDOG_EN
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    logic r_timeout;

    // A real finish in the same cycle wins over the watchdog.
    assign w_expired  = (r_state == SLOT_RUN) && !i_finish && (r_cnt == c_timeout_last);
    assign w_counting = (r_state == SLOT_START) || (r_state == SLOT_RUN);
    assign o_timeout  = r_timeout;

    always_ff @(posedge clk) begin
        if (rst || i_clear_timeout) begin
            r_timeout <= 1'b0;
        end else if (w_expired) begin
            r_timeout <= 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused   = i_clear_timeout;
    assign w_expired  = 1'b0;
    assign w_counting = (r_state == SLOT_START);
    assign o_timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_FREE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_dispatch && (r_state == SLOT_FREE)) begin
            r_cnt <= '0;
        end else if (w_counting) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // Finish is only looked at in RUN, so a level left high by the previous file is masked.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_FREE:  if (i_dispatch) w_state_next = SLOT_START;
            SLOT_START: if (r_cnt == c_start_last) w_state_next = SLOT_RUN;
            SLOT_RUN:   if (i_finish || w_expired) w_state_next = SLOT_FREE;
            default:    w_state_next = SLOT_FREE;
        endcase
    end

    always_comb begin
        o_start    = (r_state == SLOT_START);
        o_free     = (r_state == SLOT_FREE);
        o_finished = (r_state == SLOT_RUN) && (i_finish || w_expired);
    end

endmodule
`default_nettype wire

// File: rtl/encoder_batch_dispatcher.sv
`default_nettype none
//==============================================================================
// Module   : encoder_batch_dispatcher
// Desc     : Spreads one batch of file indices over N_ENG encoder engines.
//            Optional macro: WATCHDOG_EN (per-engine hang timeout).
// Revision : 1.0 - initial release
//==============================================================================
module encoder_batch_dispatcher #(
    parameter int IDX_W          = 10,
    parameter int N_ENG          = 2,
    parameter int START_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_start,
    input  logic [IDX_W-1:0]       job_first,
    input  logic [IDX_W-1:0]       job_count,
    output logic                   job_busy,
    output logic                   job_done,
    output logic [IDX_W-1:0]       files_done,
    output logic [N_ENG-1:0]       eng_start,
    output logic [N_ENG*IDX_W-1:0] eng_file_index,
    input  logic [N_ENG-1:0]       eng_finish,
    output logic [N_ENG-1:0]       eng_timeout
);
    import encoder_batch_pkg::*;

    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);
    localparam logic [N_ENG-1:0] c_eng_one = N_ENG'(1);

    batch_state_t           r_state;
    batch_state_t           w_state_next;
    logic [IDX_W-1:0]       r_next_idx;
    logic [IDX_W-1:0]       r_remaining;
    logic [IDX_W-1:0]       r_files_done;
    logic [IDX_W-1:0]       w_pop;
    logic                   r_job_busy;
    logic                   r_job_done;
    logic [N_ENG*IDX_W-1:0] r_file_index;
    logic [N_ENG-1:0]       w_free;
    logic [N_ENG-1:0]       w_grant;
    logic [N_ENG-1:0]       w_dispatch;
    logic [N_ENG-1:0]       w_finished;
    logic [N_ENG-1:0]       w_start;
    logic [N_ENG-1:0]       w_timeout;
    logic                   w_accept;

    generate
        for (genvar gi = 0; gi < N_ENG; gi++) begin : g_slot
            encoder_batch_slot #(
                .START_CYCLES  (START_CYCLES),
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_slot (
                .clk            (clk),
                .rst            (rst),
                .i_dispatch     (w_dispatch[gi]),
                .i_clear_timeout(w_accept),
                .i_finish       (eng_finish[gi]),
                .o_start        (w_start[gi]),
                .o_free         (w_free[gi]),
                .o_finished     (w_finished[gi]),
                .o_timeout      (w_timeout[gi])
            );
        end
    endgenerate

    // Lowest set bit of the free mask is the slot that takes the next file.
    assign w_grant = w_free & (~w_free + c_eng_one);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_ENG; i++) begin
            w_pop = w_pop + IDX_W'(w_finished[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (job_start) begin
                    w_state_next = (job_count == '0) ? ST_DONE : ST_DISPATCH;
                end
            end
            ST_DISPATCH: if ((|w_free) && (r_remaining == c_idx_one)) w_state_next = ST_DRAIN;
            ST_DRAIN:    if (&w_free) w_state_next = ST_DONE;
            ST_DONE:     w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == ST_IDLE) && job_start;
        w_dispatch = (r_state == ST_DISPATCH) ? w_grant : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_idx   <= '0;
            r_remaining  <= '0;
            r_files_done <= '0;
            r_job_busy   <= 1'b0;
            r_job_done   <= 1'b0;
            r_file_index <= '0;
        end else begin
            r_job_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_next_idx   <= job_first;
                r_remaining  <= job_count;
                r_files_done <= '0;
                r_job_busy   <= 1'b1;
            end else begin
                if (|w_dispatch) begin
                    r_next_idx  <= r_next_idx + c_idx_one;
                    r_remaining <= r_remaining - c_idx_one;
                end
                r_files_done <= r_files_done + w_pop;
                if (r_state == ST_DONE) begin
                    r_job_busy <= 1'b0;
                end
            end
            for (int i = 0; i < N_ENG; i++) begin
                if (w_dispatch[i]) begin
                    r_file_index[i*IDX_W +: IDX_W] <= r_next_idx;
                end
            end
        end
    end

    assign job_busy       = r_job_busy;
    assign job_done       = r_job_done;
    assign files_done     = r_files_done;
    assign eng_start      = w_start;
    assign eng_file_index = r_file_index;
    assign eng_timeout    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_encoder_batch_dispatcher.sv
`default_nettype none
//==============================================================================
// Module   : tb_encoder_batch_dispatcher
// Desc     : Directed bench with an edge-timestamp reference model and engine
//            models; watchdog scenario runs when WATCHDOG_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
module tb_encoder_batch_dispatcher;
    localparam int IDX_W          = 10;
    localparam int N_ENG          = 2;
    localparam int START_CYCLES   = 3;
    localparam int TIMEOUT_CYCLES = 50;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   job_start = 1'b0;
    logic [IDX_W-1:0]       job_first = '0;
    logic [IDX_W-1:0]       job_count = '0;
    logic                   job_busy;
    logic                   job_done;
    logic [IDX_W-1:0]       files_done;
    logic [N_ENG-1:0]       eng_start;
    logic [N_ENG*IDX_W-1:0] eng_file_index;
    logic [N_ENG-1:0]       eng_finish = '0;
    logic [N_ENG-1:0]       eng_timeout;

    encoder_batch_dispatcher #(
        .IDX_W         (IDX_W),
        .N_ENG         (N_ENG),
        .START_CYCLES  (START_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_start     (job_start),
        .job_first     (job_first),
        .job_count     (job_count),
        .job_busy      (job_busy),
        .job_done      (job_done),
        .files_done    (files_done),
        .eng_start     (eng_start),
        .eng_file_index(eng_file_index),
        .eng_finish    (eng_finish),
        .eng_timeout   (eng_timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Engine model: finish stays high until the next start falls, then rises
    // e_delay cycles later (never, if hung).
    int e_delay [N_ENG];
    bit e_hang  [N_ENG];
    bit e_seen  [N_ENG];
    int e_cnt   [N_ENG];

    always @(negedge clk) begin : engines
        for (int i = 0; i < N_ENG; i++) begin
            if (eng_start[i]) begin
                e_seen[i] = 1'b1;
                e_cnt[i]  = 0;
            end else if (e_seen[i]) begin
                e_seen[i]     = 1'b0;
                eng_finish[i] = 1'b0;
                e_cnt[i]      = e_delay[i];
            end else if (e_cnt[i] > 0) begin
                e_cnt[i]--;
                if (e_cnt[i] == 0 && !e_hang[i]) eng_finish[i] = 1'b1;
            end
        end
    end

    // Reference model: each engine is described by the edge it was handed a
    // file (m_d); start is high for START_CYCLES edges from there, and a finish
    // counts only on edges after that window.
    int               cyc = 0;
    int               m_phase = 0;   // 0 idle, 1 handing out files, 2 waiting, 3 done
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    int               m_files = 0;
    int               m_left = 0;
    logic [IDX_W-1:0] m_next = '0;
    bit               m_active [N_ENG];
    int               m_d      [N_ENG];
    logic [IDX_W-1:0] m_idx    [N_ENG];
    bit               m_to     [N_ENG];

    always @(posedge clk) begin : model
        bit pre_active [N_ENG];
        int pre_phase;
        int pick;
        bit all_idle;
        cyc++;
        if (rst) begin
            m_phase = 0; m_busy = 1'b0; m_done = 1'b0; m_files = 0; m_left = 0; m_next = '0;
            for (int i = 0; i < N_ENG; i++) begin
                m_active[i] = 1'b0; m_idx[i] = '0; m_to[i] = 1'b0; m_d[i] = 0;
            end
        end else begin
            pre_active = m_active;
            pre_phase  = m_phase;
            m_done     = 1'b0;
            for (int i = 0; i < N_ENG; i++) begin
                if (m_active[i] && cyc > m_d[i] + START_CYCLES && eng_finish[i]) begin
                    m_active[i] = 1'b0;
                    m_files++;
                end
`ifdef WATCHDOG_EN
                else if (m_active[i] && cyc - m_d[i] == TIMEOUT_CYCLES) begin
                    m_active[i] = 1'b0;
                    m_to[i]     = 1'b1;
                    m_files++;
                end
`endif
            end
            pick = -1;
            all_idle = 1'b1;
            for (int i = N_ENG - 1; i >= 0; i--) begin
                if (!pre_active[i]) pick = i;
                else all_idle = 1'b0;
            end
            case (pre_phase)
                0: if (job_start) begin
                    m_next  = job_first;
                    m_left  = int'(job_count);
                    m_files = 0;
                    m_busy  = 1'b1;
                    for (int i = 0; i < N_ENG; i++) m_to[i] = 1'b0;
                    m_phase = (job_count == '0) ? 3 : 1;
                end
                1: if (pick >= 0) begin
                    m_active[pick] = 1'b1;
                    m_d[pick]      = cyc;
                    m_idx[pick]    = m_next;
                    m_next         = m_next + 1'b1;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (all_idle) m_phase = 3;
                default: begin
                    m_phase = 0; m_done = 1'b1; m_busy = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic [N_ENG*IDX_W-1:0] exp_idx;
        logic [N_ENG-1:0]       exp_start;
        logic [N_ENG-1:0]       exp_to;
        if (chk_en) begin
            for (int i = 0; i < N_ENG; i++) begin
                exp_start[i] = m_active[i] && (cyc < m_d[i] + START_CYCLES);
                exp_idx[i*IDX_W +: IDX_W] = m_idx[i];
                exp_to[i] = m_to[i];
            end
            chk("job_busy", job_busy, m_busy);
            chk("job_done", job_done, m_done);
            chk("files_done", files_done, m_files);
            chk("eng_start", eng_start, exp_start);
            chk("eng_file_index", eng_file_index, exp_idx);
            chk("eng_timeout", eng_timeout, exp_to);
        end
    end

    // Issued-index log and simultaneous-finish detector.
    logic [IDX_W-1:0] issued [$];
    logic [N_ENG-1:0] mon_prev = '0;
    logic [IDX_W-1:0] prev_fd = '0;
    bit               seen_double = 1'b0;

    always @(negedge clk) begin : monitor
        for (int i = 0; i < N_ENG; i++) begin
            if (eng_start[i] && !mon_prev[i]) issued.push_back(eng_file_index[i*IDX_W +: IDX_W]);
        end
        mon_prev = eng_start;
        if (files_done == prev_fd + IDX_W'(2)) seen_double = 1'b1;
        prev_fd = files_done;
    end

    task automatic start_job(input logic [IDX_W-1:0] first, input logic [IDX_W-1:0] count);
        job_first = first;
        job_count = count;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc, output int waited);
        waited = 0;
        while (!job_done && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_done_seen"}, job_done, 1);
    endtask

    task automatic set_delays(input int d0, input int d1);
        e_delay[0] = d0;
        e_delay[1] = d1;
    endtask

    initial begin : stimulus
        int w;
        logic [IDX_W-1:0] exp3 [8];
        exp3 = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd2, 10'd3};
        set_delays(20, 20);
        e_hang[0] = 1'b0;
        e_hang[1] = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", job_busy, 0);
        chk("reset_files_done", files_done, 0);
        chk("reset_eng_start", eng_start, 0);

        // Plain batch of 8 with a job_start poke while busy.
        issued.delete();
        start_job(10'd0, 10'd8);
        repeat (6) @(negedge clk);
        job_first = 10'd500;
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
        wait_done("t1", 400, w);
        chk("t1_files_done", files_done, 8);
        chk("t1_busy_falls_with_done", job_busy, 0);
        chk("t1_issued_count", issued.size(), 8);
        for (int j = 0; j < 8 && j < issued.size(); j++) chk("t1_issued_idx", issued[j], j);
        @(negedge clk);

        // Empty batch.
        issued.delete();
        start_job(10'd0, 10'd0);
        wait_done("t2", 20, w);
        chk("t2_done_latency", w, 1);
        chk("t2_files_done", files_done, 0);
        @(negedge clk);
        chk("t2_no_starts", issued.size(), 0);

        // Index wraparound.
        issued.delete();
        set_delays(3, 7);
        start_job(10'd1020, 10'd8);
        wait_done("t3", 300, w);
        chk("t3_issued_count", issued.size(), 8);
        for (int j = 0; j < 8 && j < issued.size(); j++) chk("t3_issued_idx", issued[j], exp3[j]);
        @(negedge clk);

        // Both engines finish on the same edge.
        seen_double = 1'b0;
        set_delays(11, 10);
        start_job(10'd40, 10'd4);
        wait_done("t4", 300, w);
        chk("t4_double_increment", seen_double, 1);
        chk("t4_files_done", files_done, 4);
        @(negedge clk);

        // Finish still high from the previous batch while start is up.
        set_delays(20, 20);
        start_job(10'd10, 10'd2);
        repeat (5) @(negedge clk);
        chk("t5_stale_masked", files_done, 0);
        wait_done("t5", 200, w);
        chk("t5_files_done", files_done, 2);
        @(negedge clk);

        // Reset mid-dispatch with 3 files not yet handed out.
        set_delays(30, 30);
        start_job(10'd200, 10'd5);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_busy", job_busy, 0);
        chk("t6_rst_done", job_done, 0);
        chk("t6_rst_start", eng_start, 0);
        chk("t6_rst_index", eng_file_index, 0);
        chk("t6_rst_files_done", files_done, 0);
        issued.delete();
        set_delays(4, 4);
        start_job(10'd300, 10'd3);
        wait_done("t6", 200, w);
        chk("t6_files_done", files_done, 3);
        chk("t6_issued_count", issued.size(), 3);
        for (int j = 0; j < 3 && j < issued.size(); j++) chk("t6_issued_idx", issued[j], 300 + j);
        @(negedge clk);

`ifdef WATCHDOG_EN
        // Engine 1 never finishes.
        e_hang[1] = 1'b1;
        set_delays(5, 5);
        start_job(10'd0, 10'd4);
        wait_done("t7", 600, w);
        chk("t7_timeout_flags", eng_timeout, 2'b10);
        chk("t7_files_done", files_done, 4);
        @(negedge clk);
        e_hang[1] = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: got no summary, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
